segmented_add_controller: RTL and testbench
===========================================

Name: segmented_add_controller

Overview:
Multi-cycle controller that sequences one narrow W-bit adder slice over an N-bit signed addition, least-significant slice first, with a registered carry between slices. It trades latency for area next to the family of single-cycle adders. A start/busy/done handshake frames each operation. Results stay registered until the next accepted start.

Parameters:
N, 32, operand/sum width in bits; must be a multiple of W.
W, 8, width of the adder slice in bits; S = N/W slices per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled at the clk edge
A  input  N  signed operand A; sampled only when start is accepted
B  input  N  signed operand B; sampled only when start is accepted
Cin  input  1  carry-in to slice 0; sampled with A/B
busy  output  1  high while slices are being processed
done  output  1  one-cycle pulse when Sum/Cout/Overflow become valid
Sum  output  N  signed result
Cout  output  1  carry out of bit N-1
Overflow  output  1  signed overflow

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state IDLE; busy=0, done=0, Sum=0, Cout=0, Overflow=0; slice counter=0; carry register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch A, B and Cin, clear the counter, set the carry register to Cin, then go to RUN.
  - Otherwise remain in IDLE.
- RUN (busy=1):
  - Each cycle, slice k adds A[kW+W-1:kW] + B[kW+W-1:kW] + carry register.
  - Write the slice result into Sum[kW+W-1:kW], update the carry register with the slice carry-out, then increment k.
  - On the slice with k=S-1, also register Cout = slice carry-out.
  - On that same slice, register Overflow = carry into bit N-1 XOR carry out of bit N-1.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - If start=1 in this cycle, accept it exactly as IDLE does (back-to-back operation) and go to RUN. Otherwise go to IDLE.
- Latency: start accepted at edge t0. Slices are processed at edges t0+1 through t0+S. done is high in the cycle after edge t0+S.
- Sum is updated slice by slice during RUN. Sum is guaranteed only while done=1 or afterwards, until the next accepted start. Cout and Overflow change only at the final slice.
- start while in RUN is ignored: no re-latch and no effect on the counter.
- Inputs A/B/Cin changing after acceptance have no effect.
- rst asserted mid-operation aborts it. All state and outputs return to reset values at that edge, and done is not pulsed.
- rst and start high in the same cycle: rst wins.
- S=1 (W=N) is legal: RUN lasts one cycle.
- Cout is the carry out of the full N-bit unsigned sum; Overflow follows the two's-complement rule.

Optional Feature:
- Macro: SEGMENTED_ADD_SUB_EN.
- Defined:
  - Adds an input port Sub (1 bit), sampled with A/B at start acceptance.
  - Sub=1 computes A-B: latch ~B and force the initial carry to 1, ignoring Cin.
  - Overflow/Cout follow the same rules on the effective operands.
- Undefined: no Sub port; addition only.

Decomposition:
- Shared package:
  - State encoding constants IDLE/RUN/DONE (2-bit).
  - Default N and W.
  - Function computing S = N/W.
- Sub-module add_slice (W-bit ripple adder):
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb_in (carry into its MSB, needed for Overflow on the final slice).
- Controller holds the FSM, counter, operand/carry registers and output registers.

Test Plan:
1. N=32, W=8: A=20, B=30, Cin=0, start for 1 cycle -> busy for 4 cycles, then done pulses once; Sum=50, Cout=0, Overflow=0.
2. A=-5, B=-7, Cin=0 -> Sum=-12 (0xFFFFFFF4), Cout=1, Overflow=0.
3. A=0x7FFFFFFF, B=1, Cin=0 -> Sum=0x80000000, Cout=0, Overflow=1.
4. A=0x80000000, B=0xFFFFFFFF -> Sum=0x7FFFFFFF, Cout=1, Overflow=1.
5. A=0x000000FF, B=0x00000001, Cin=1 -> Sum=0x101 (inter-slice carry ripple). Also pulse start with other operands mid-RUN -> ignored, same result.
6. Start A=20, B=30, then assert rst after 2 RUN cycles -> next edge: busy=0, done never pulses, Sum=0. A new start afterwards completes normally.

Source files
------------

// File: rtl/segmented_add_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : segmented_add_controller_pkg
// Purpose  : Shared definitions for the segmented adder controller.
//            Provides the FSM state encoding, the default operand and slice
//            widths, and a helper that returns the slice count S = N/W.
// Revision : 1.0 - initial release
// ============================================================================
package segmented_add_controller_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Default operand width and adder slice width
    localparam int DEFAULT_N = 32;
    localparam int DEFAULT_W = 8;

    // Number of W-bit slices needed to cover an N-bit operand
    function automatic int num_slices(input int n, input int w);
        return n / w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/segmented_add_controller_add_slice.sv
`default_nettype none
// ============================================================================
// Module   : add_slice
// Purpose  : W-bit ripple-carry adder slice.
// Ports    : a, b      - W-bit addends
//            ci        - carry into bit 0
//            s         - W-bit sum
//            co        - carry out of bit W-1
//            c_msb_in  - carry into bit W-1 (used for signed overflow)
// Revision : 1.0 - initial release
// ============================================================================
module add_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    // c[i] is the carry into bit i; c[W] is the carry out of the slice
    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co       = c[W];
    assign c_msb_in = c[W-1];

endmodule
`default_nettype wire

// File: rtl/segmented_add_controller.sv
`default_nettype none
// ============================================================================
// Module   : segmented_add_controller
// Purpose  : Multi-cycle N-bit signed adder that reuses one W-bit slice,
//            processing the least-significant slice first and carrying
//            between slices through a register. Framed by start/busy/done.
// Ports    : clk, rst (sync, active-high)
//            start        - request; A/B/Cin (and Sub) sampled on acceptance
//            A, B, Cin    - operands and carry-in
//            Sub          - optional: 1 computes A-B (SEGMENTED_ADD_SUB_EN)
//            busy         - high while slices are being processed
//            done         - one-cycle pulse when results are valid
//            Sum, Cout, Overflow - registered results
// Config   : define SEGMENTED_ADD_SUB_EN to add the Sub port (A-B support)
// Revision : 1.0 - initial release
// ============================================================================
module segmented_add_controller
    import segmented_add_controller_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
`ifdef SEGMENTED_ADD_SUB_EN
    input  logic         Sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Overflow
);

    localparam int S  = num_slices(N, W);
    localparam int KW = (S > 1) ? $clog2(S) : 1;
    localparam logic [KW-1:0] LAST_SLICE = KW'(S - 1);

    logic [1:0]    state;
    logic [N-1:0]  a_op;
    logic [N-1:0]  b_op;
    logic          carry;
    logic [KW-1:0] slice_idx;

    // Effective operands at acceptance; subtraction is A + ~B + 1
    logic [N-1:0]  b_eff;
    logic          c_init;

`ifdef SEGMENTED_ADD_SUB_EN
    always_comb begin
        b_eff  = Sub ? ~B : B;
        c_init = Sub ? 1'b1 : Cin;
    end
`else
    always_comb begin
        b_eff  = B;
        c_init = Cin;
    end
`endif

    logic [W-1:0] slice_a;
    logic [W-1:0] slice_b;
    logic [W-1:0] slice_s;
    logic         slice_co;
    logic         slice_c_msb;

    assign slice_a = a_op[int'(slice_idx) * W +: W];
    assign slice_b = b_op[int'(slice_idx) * W +: W];

    add_slice #(
        .W (W)
    ) u_add_slice (
        .a        (slice_a),
        .b        (slice_b),
        .ci       (carry),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_c_msb)
    );

    // busy/done decode directly from state so they follow reset and abort
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_op      <= '0;
            b_op      <= '0;
            carry     <= 1'b0;
            slice_idx <= '0;
            Sum       <= '0;
            Cout      <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE (back-to-back)
                IDLE, DONE: begin
                    if (start) begin
                        a_op      <= A;
                        b_op      <= b_eff;
                        carry     <= c_init;
                        slice_idx <= '0;
                        state     <= RUN;
                    end else begin
                        state     <= IDLE;
                    end
                end
                RUN: begin
                    Sum[int'(slice_idx) * W +: W] <= slice_s;
                    carry     <= slice_co;
                    slice_idx <= slice_idx + 1'b1;
                    if (slice_idx == LAST_SLICE) begin
                        // Slice MSB is bit N-1 of the full sum
                        Cout     <= slice_co;
                        Overflow <= slice_c_msb ^ slice_co;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_segmented_add_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_segmented_add_controller
// Purpose  : Self-checking bench for segmented_add_controller (N=32, W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_segmented_add_controller;

    localparam int N = 32;
    localparam int S = 4;
    localparam longint MAXV = 64'sh7FFFFFFF;
    localparam longint MINV = -64'sh80000000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  A = '0;
    logic [N-1:0]  B = '0;
    logic          Cin = 1'b0;
`ifdef SEGMENTED_ADD_SUB_EN
    logic          Sub = 1'b0;
`endif
    logic          busy;
    logic          done;
    logic [N-1:0]  Sum;
    logic          Cout;
    logic          Overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    // Results captured by do_op
    logic [N-1:0] got_sum;
    logic         got_cout;
    logic         got_ovf;
    int           busy_cnt;
    bit           saw_done;
    logic         done_after;

    always #5 clk = ~clk;

    segmented_add_controller #(
        .N (32),
        .W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
`ifdef SEGMENTED_ADD_SUB_EN
        .Sub      (Sub),
`endif
        .busy     (busy),
        .done     (done),
        .Sum      (Sum),
        .Cout     (Cout),
        .Overflow (Overflow)
    );

    // Reference: full-width arithmetic, unsigned for Cout, signed range for Overflow
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic ci);
        logic [N:0] u;
        longint     s;
        logic       ov;
        u  = {1'b0, a} + {1'b0, b} + (N+1)'(ci);
        s  = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        ov = (s > MAXV) || (s < MINV);
        return {ov, u[N], u[N-1:0]};
    endfunction

    // Issue one operation, optionally pulsing start mid-RUN, and collect results
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                         input bit glitch_start);
        @(negedge clk);
        A = a; B = b; Cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inputs scrambled after acceptance must not matter
        A = $urandom; B = $urandom; Cin = 1'($urandom);
        busy_cnt = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 20 && !saw_done; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                saw_done = 1'b1;
            end else begin
                start = (glitch_start && i == 1);
                @(negedge clk);
            end
        end
        start    = 1'b0;
        got_sum  = Sum;
        got_cout = Cout;
        got_ovf  = Overflow;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; A = 32'd7; B = 32'd9;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, Cout, Overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000", {busy, done, Cout, Overflow});
        end
        n_cmp++;
        if (Sum !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_sum: got %h required 00000000", Sum);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins_over_start: busy got %b required 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [5];
        logic [N-1:0] tb [5];
        logic         tc [5];
        logic [N-1:0] es [5];
        logic         eco [5];
        logic         eov [5];
        ta[0] = 32'd20;       tb[0] = 32'd30;       tc[0] = 1'b0; es[0] = 32'd50;       eco[0] = 1'b0; eov[0] = 1'b0;
        ta[1] = -32'sd5;      tb[1] = -32'sd7;      tc[1] = 1'b0; es[1] = 32'hFFFFFFF4; eco[1] = 1'b1; eov[1] = 1'b0;
        ta[2] = 32'h7FFFFFFF; tb[2] = 32'd1;        tc[2] = 1'b0; es[2] = 32'h80000000; eco[2] = 1'b0; eov[2] = 1'b1;
        ta[3] = 32'h80000000; tb[3] = 32'hFFFFFFFF; tc[3] = 1'b0; es[3] = 32'h7FFFFFFF; eco[3] = 1'b1; eov[3] = 1'b1;
        ta[4] = 32'h000000FF; tb[4] = 32'h00000001; tc[4] = 1'b1; es[4] = 32'h00000101; eco[4] = 1'b0; eov[4] = 1'b0;
        for (int v = 0; v < 5; v++) begin
            // Last vector also pulses start mid-RUN, which must be ignored
            do_op(ta[v], tb[v], tc[v], v == 4);
            n_cmp++;
            if (!saw_done) begin
                n_fail++;
                $display("FAIL dir%0d_timeout: done got none required pulse", v);
            end
            n_cmp++;
            if (busy_cnt != S) begin
                n_fail++;
                $display("FAIL dir%0d_busy_cycles: got %0d required %0d", v, busy_cnt, S);
            end
            n_cmp++;
            if (got_sum !== es[v]) begin
                n_fail++;
                $display("FAIL dir%0d_sum: got %h required %h", v, got_sum, es[v]);
            end
            n_cmp++;
            if ({got_cout, got_ovf} !== {eco[v], eov[v]}) begin
                n_fail++;
                $display("FAIL dir%0d_cout_ovf: got %b required %b", v, {got_cout, got_ovf},
                         {eco[v], eov[v]});
            end
            n_cmp++;
            if (done_after !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_done_width: got %b required 0", v, done_after);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        logic         ci;
        logic [N+1:0] exp;
        for (int r = 0; r < 12; r++) begin
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom);
            if (r == 0) begin a = 32'h80000000; b = 32'h80000000; end
            exp = model(a, b, ci);
            do_op(a, b, ci, 1'($urandom));
            n_cmp++;
            if (!saw_done || busy_cnt != S) begin
                n_fail++;
                $display("FAIL rand%0d_timing: busy %0d done %0b required %0d 1", r, busy_cnt,
                         saw_done, S);
            end
            n_cmp++;
            if ({got_ovf, got_cout, got_sum} !== exp) begin
                n_fail++;
                $display("FAIL rand%0d_result: a %h b %h ci %b got ovf/cout/sum %b %b %h required %b %b %h",
                         r, a, b, ci, got_ovf, got_cout, got_sum, exp[N+1], exp[N], exp[N-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N+1:0] exp1, exp2;
        int           cnt;
        bit           seen;
        exp1 = model(32'h12345678, 32'h0FEDCBA9, 1'b1);
        exp2 = model(32'hFFFFFF00, 32'h00000100, 1'b0);
        @(negedge clk);
        A = 32'h12345678; B = 32'h0FEDCBA9; Cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen || {Overflow, Cout, Sum} !== exp1) begin
            n_fail++;
            $display("FAIL b2b_first: done %b got %b %b %h required %b %b %h", seen, Overflow,
                     Cout, Sum, exp1[N+1], exp1[N], exp1[N-1:0]);
        end
        // Start presented during the done cycle is accepted immediately
        A = 32'hFFFFFF00; B = 32'h00000100; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busy) cnt++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen || cnt != S) begin
            n_fail++;
            $display("FAIL b2b_second_timing: busy %0d done %b required %0d 1", cnt, seen, S);
        end
        n_cmp++;
        if ({Overflow, Cout, Sum} !== exp2) begin
            n_fail++;
            $display("FAIL b2b_second_result: got %b %b %h required %b %b %h", Overflow, Cout,
                     Sum, exp2[N+1], exp2[N], exp2[N-1:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clk);
        A = 32'd20; B = 32'd30; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, Cout, Overflow} !== 4'b0000 || Sum !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_state: got busy %b done %b cout %b ovf %b sum %h required all 0",
                     busy, done, Cout, Overflow, Sum);
        end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles required 0", pulses);
        end
        do_op(32'd20, 32'd30, 1'b0, 1'b0);
        n_cmp++;
        if (!saw_done || got_sum !== 32'd50) begin
            n_fail++;
            $display("FAIL abort_recover: done %b sum %h required 1 00000032", saw_done, got_sum);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
